// File: rtl/bist_response_compactor.sv
// BIST response compactor: folds accepted response vectors into a Galois MISR
// and compares the final signature with a golden value. Optional RESP_XMASK_EN adds an xmask port.
module bist_response_compactor #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned PATTERN_CNT = 256,
   parameter logic [31:0] MISR_POLY   = 32'h04C11DB7,
   parameter logic [31:0] MISR_SEED   = 32'h00000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] golden,
   input  logic             resp_valid,
   input  logic [WIDTH-1:0] resp_data,
`ifdef RESP_XMASK_EN
   input  logic [WIDTH-1:0] xmask,
`endif
   output logic             resp_ready,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] signature,
   output logic [CNT_W-1:0] pat_count
);

   localparam logic [WIDTH-1:0] POLY     = WIDTH'(MISR_POLY);
   localparam logic [WIDTH-1:0] SEED     = WIDTH'(MISR_SEED);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PATTERN_CNT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      CMP  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state, state_d;
   logic [WIDTH-1:0] sig_d;
   logic [CNT_W-1:0] cnt_d;
   logic             done_d, pass_d, ready_d, busy_d;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] misr_next;
   logic             xfer;

`ifdef RESP_XMASK_EN
   assign data_in = resp_data & ~xmask;
`else
   assign data_in = resp_data;
`endif

   // resp_ready is already a registered decode of state==RUN
   assign xfer      = resp_valid & resp_ready;
   assign misr_next = {signature[WIDTH-2:0], 1'b0}
                    ^ (signature[WIDTH-1] ? POLY : '0)
                    ^ data_in;

   // Next-state and next-output logic
   always_comb begin
      state_d = state;
      sig_d   = signature;
      cnt_d   = pat_count;
      done_d  = done;
      pass_d  = pass;

      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               sig_d   = SEED;
               cnt_d   = '0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end
         end
         RUN: begin
            if (xfer) begin
               sig_d = misr_next;
               cnt_d = pat_count + CNT_W'(1);
               if (pat_count == LAST_IDX) begin
                  state_d = CMP;
               end
            end
         end
         CMP: begin
            pass_d  = (signature == golden);
            done_d  = 1'b1;
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ready_d = (state_d == RUN);
      busy_d  = (state_d == RUN) || (state_d == CMP);
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         signature  <= SEED;
         pat_count  <= '0;
         done       <= 1'b0;
         pass       <= 1'b0;
         resp_ready <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_d;
         signature  <= sig_d;
         pat_count  <= cnt_d;
         done       <= done_d;
         pass       <= pass_d;
         resp_ready <= ready_d;
         busy       <= busy_d;
      end
   end

endmodule

// File: tb/tb_bist_response_compactor.sv
// Self-checking bench for bist_response_compactor: three instances (1, 2 and 256
// patterns) driven by directed and randomized steps against a polynomial-arithmetic model.
module tb_bist_response_compactor;

   localparam logic [31:0] POLY = 32'h04C11DB7;

   logic        clk = 1'b0;
   logic        rst;
   logic        start1, start2, start256;
   logic [31:0] golden;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic [31:0] xmask;

   logic        rdy1, busy1, done1, pass1;
   logic [31:0] sig1;
   logic [15:0] cnt1;
   logic        rdy2, busy2, done2, pass2;
   logic [31:0] sig2;
   logic [15:0] cnt2;
   logic        rdy3, busy3, done3, pass3;
   logic [31:0] sig3;
   logic [15:0] cnt3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bist_response_compactor #(.PATTERN_CNT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .golden(golden),
      .resp_valid(resp_valid), .resp_data(resp_data),
`ifdef RESP_XMASK_EN
      .xmask(xmask),
`endif
      .resp_ready(rdy1), .busy(busy1), .done(done1), .pass(pass1),
      .signature(sig1), .pat_count(cnt1));

   bist_response_compactor #(.PATTERN_CNT(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .golden(golden),
      .resp_valid(resp_valid), .resp_data(resp_data),
`ifdef RESP_XMASK_EN
      .xmask(xmask),
`endif
      .resp_ready(rdy2), .busy(busy2), .done(done2), .pass(pass2),
      .signature(sig2), .pat_count(cnt2));

   bist_response_compactor #(.PATTERN_CNT(256)) dut256 (
      .clk(clk), .rst(rst), .start(start256), .golden(golden),
      .resp_valid(resp_valid), .resp_data(resp_data),
`ifdef RESP_XMASK_EN
      .xmask(xmask),
`endif
      .resp_ready(rdy3), .busy(busy3), .done(done3), .pass(pass3),
      .signature(sig3), .pat_count(cnt3));

   // Signature as polynomial arithmetic over GF(2): s(x)*x mod P(x) + d(x)
   function automatic logic [31:0] misr_ref(input logic [31:0] words[$]);
      logic [32:0] acc;
      acc = '0;
      foreach (words[i]) begin
         acc = {acc[31:0], 1'b0};
         if (acc[32]) acc = acc ^ {1'b1, POLY};
         acc = {1'b0, acc[31:0] ^ words[i]};
      end
      return acc[31:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic feed(input logic [31:0] d);
      resp_valid = 1'b1;
      resp_data  = d;
      @(negedge clk);
      resp_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] q[$];
      logic [31:0] exp_sig;
      int          model_cnt;
      bit          finished;

      rst = 1'b1; start1 = 0; start2 = 0; start256 = 0;
      golden = '0; resp_valid = 0; resp_data = '0; xmask = '0;

      // Reset state
      @(negedge clk);
      chk("rst_sig", sig3, 32'h0);
      chk("rst_cnt", 32'(cnt3), 32'd0);
      chk("rst_ready", 32'(rdy3), 32'd0);
      chk("rst_busy", 32'(busy3), 32'd0);
      chk("rst_done", 32'(done3), 32'd0);
      chk("rst_pass", 32'(pass3), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // resp_valid while idle absorbs nothing
      feed($urandom); feed($urandom); feed($urandom);
      chk("idle_cnt", 32'(cnt3), 32'd0);
      chk("idle_sig", sig3, 32'h0);

      // Abort mid-run with rst after three transfers
      start256 = 1'b1; @(negedge clk); start256 = 1'b0;
      chk("run_ready", 32'(rdy3), 32'd1);
      chk("run_busy", 32'(busy3), 32'd1);
      q = {};
      for (int i = 0; i < 3; i++) begin
         q.push_back($urandom);
         feed(q[i]);
      end
      chk("mid_cnt", 32'(cnt3), 32'd3);
      chk("mid_sig", sig3, misr_ref(q));
      rst = 1'b1;
      #1;
      chk("abort_sig", sig3, 32'h0);
      chk("abort_cnt", 32'(cnt3), 32'd0);
      chk("abort_ready", 32'(rdy3), 32'd0);
      chk("abort_done", 32'(done3), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 32'(rdy3), 32'd0);
      chk("post_rst_cnt", 32'(cnt3), 32'd0);
      chk("post_rst_busy", 32'(busy3), 32'd0);

      // Single-pattern run: done two edges after the transfer
      golden = 32'h00000001;
      start1 = 1'b1; @(negedge clk); start1 = 1'b0;
      feed(32'h00000001);
      chk("p1_sig", sig1, 32'h00000001);
      chk("p1_done_early", 32'(done1), 32'd0);
      chk("p1_busy_cmp", 32'(busy1), 32'd1);
      chk("p1_ready_cmp", 32'(rdy1), 32'd0);
      @(negedge clk);
      chk("p1_done", 32'(done1), 32'd1);
      chk("p1_pass", 32'(pass1), 32'd1);
      chk("p1_busy_done", 32'(busy1), 32'd0);
      @(negedge clk);
      chk("p1_done_hold", 32'(done1), 32'd1);

      // Two-pattern run exercising the feedback tap, then fail case
      golden = POLY;
      start2 = 1'b1; @(negedge clk); start2 = 1'b0;
      feed(32'h80000000); feed(32'h00000000);
      chk("p2_sig", sig2, 32'h04C11DB7);
      chk("p2_cnt", 32'(cnt2), 32'd2);
      @(negedge clk);
      chk("p2_pass", 32'(pass2), 32'd1);
      chk("p2_done", 32'(done2), 32'd1);
      golden = 32'h0;
      start2 = 1'b1; @(negedge clk); start2 = 1'b0;
      chk("p2_restart_done", 32'(done2), 32'd0);
      chk("p2_restart_pass", 32'(pass2), 32'd0);
      chk("p2_restart_sig", sig2, 32'h0);
      feed(32'h80000000); feed(32'h00000000);
      @(negedge clk);
      chk("p2_fail_done", 32'(done2), 32'd1);
      chk("p2_fail_pass", 32'(pass2), 32'd0);

      // 256 patterns with random gaps, a stray start, and start on the final transfer
      q = {};
      model_cnt = 0;
      finished = 0;
      start256 = 1'b1; @(negedge clk); start256 = 1'b0;
      for (int it = 0; it < 4000; it++) begin
         resp_valid = 1'b0;
         start256   = 1'b0;
         chk("gap_cnt", 32'(cnt3), 32'(model_cnt));
         if (model_cnt == 256) begin
            finished = 1;
            break;
         end
         resp_valid = 1'($urandom_range(0, 1));
         resp_data  = $urandom;
         if (resp_valid) begin
            q.push_back(resp_data);
            model_cnt++;
            if (model_cnt == 256) start256 = 1'b1;
         end
         if (it == 40) start256 = 1'b1;
         @(negedge clk);
      end
      chk("r256_finished", 32'(finished), 32'd1);
      exp_sig = misr_ref(q);
      chk("r256_sig", sig3, exp_sig);
      chk("r256_busy_cmp", 32'(busy3), 32'd1);
      chk("r256_ready_cmp", 32'(rdy3), 32'd0);
      golden = exp_sig;
      @(negedge clk);
      chk("r256_done", 32'(done3), 32'd1);
      chk("r256_pass", 32'(pass3), 32'd1);
      chk("r256_cnt_cap", 32'(cnt3), 32'd256);

      // Restart from DONE with the same data back to back
      start256 = 1'b1; @(negedge clk); start256 = 1'b0;
      chk("rs_done", 32'(done3), 32'd0);
      chk("rs_pass", 32'(pass3), 32'd0);
      chk("rs_sig", sig3, 32'h0);
      chk("rs_cnt", 32'(cnt3), 32'd0);
      foreach (q[i]) feed(q[i]);
      chk("rs_sig_final", sig3, exp_sig);
      @(negedge clk);
      chk("rs_pass_final", 32'(pass3), 32'd1);

`ifdef RESP_XMASK_EN
      // Fully masked responses leave the seed untouched
      xmask  = 32'hFFFFFFFF;
      golden = 32'h0;
      start2 = 1'b1; @(negedge clk); start2 = 1'b0;
      feed($urandom); feed($urandom);
      chk("xm_all_sig", sig2, 32'h0);
      @(negedge clk);
      chk("xm_all_pass", 32'(pass2), 32'd1);
      xmask = 32'h0;
      q = {32'h80000000, 32'h00000000};
      start2 = 1'b1; @(negedge clk); start2 = 1'b0;
      feed(q[0]); feed(q[1]);
      chk("xm_none_sig", sig2, misr_ref(q));
      // Partial mask: only unmasked bits reach the MISR
      xmask = 32'h0000FFFF;
      start2 = 1'b1; @(negedge clk); @(negedge clk); start2 = 1'b0;
      q = {32'h1234ABCD, 32'hFFFF0F0F};
      feed(q[0]); feed(q[1]);
      q = {32'h12340000, 32'hFFFF0000};
      chk("xm_part_sig", sig2, misr_ref(q));
      xmask = 32'h0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bist_response_compactor.md
Name: bist_response_compactor

Overview:
- Downstream consumer of the generated combinational benchmark circuits (32 primary outputs).
- Captures one 32-bit response vector per accepted transfer and folds it into a multiple-input signature register (MISR).
- After a programmed number of patterns, compares the signature against a golden value and reports pass/fail.
- Sits between the benchmark under test and the test controller in the BIST wrapper.

Parameters:
- WIDTH, 32, response vector and signature width.
- CNT_W, 16, width of the pattern counter.
- PATTERN_CNT, 256, number of responses compacted per run (1 to 2^CNT_W-1).
- MISR_POLY, 32'h04C11DB7, Galois feedback polynomial; low WIDTH bits are used.
- MISR_SEED, 32'h00000000, signature value loaded on reset and on start.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a run.
- golden  in  WIDTH  expected signature; sampled in the cycle the FSM enters CMP.
- resp_valid  in  1  response vector valid.
- resp_data  in  WIDTH  response vector from the benchmark outputs.
- resp_ready  out  1  block accepts a response this cycle.
- busy  out  1  run in progress (RUN or CMP).
- done  out  1  run complete; held until the next start or rst.
- pass  out  1  signature matched golden; meaningful only while done=1.
- signature  out  WIDTH  current MISR contents.
- pat_count  out  CNT_W  number of responses accepted in the current run.

Behaviour:
- Reset (async, immediate): state IDLE; signature=MISR_SEED; pat_count=0; resp_ready, busy, done and pass all 0.
- States and transitions:
  - IDLE: start -> RUN.
  - RUN: transition to CMP on the accepting transfer that makes pat_count == PATTERN_CNT.
  - CMP: -> DONE after exactly 1 cycle.
  - DONE: start -> RUN.
- On entering RUN: signature<=MISR_SEED, pat_count<=0, done<=0, pass<=0.
- resp_ready = (state==RUN), a registered-state decode. A transfer occurs when resp_valid && resp_ready.
- MISR update on each transfer: sig_next = {sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? MISR_POLY : 0) ^ data_in, with data_in=resp_data.
- pat_count increments by 1 on each transfer. With no transfer, signature and pat_count hold.
- CMP cycle: pass<=(signature==golden), done<=1 on the transition to DONE. Latency from the last transfer edge to done=1 is 2 clock edges.
- busy=1 in RUN and CMP.
- start while in RUN or CMP is ignored.
- start in DONE restarts the run and clears done/pass on the next edge.
- start and the final transfer in the same cycle: start is ignored.
- resp_valid is ignored outside RUN; no data is absorbed. Upstream holds resp_data stable while resp_valid=1 && resp_ready=0.
- rst asserted mid-run aborts immediately to the reset values; there is no partial result.
- pat_count never exceeds PATTERN_CNT.

Optional Feature:
- Macro: RESP_XMASK_EN.
- Defined:
  - Adds port xmask  in  WIDTH (bit=1 marks an unknown or don't-care output).
  - data_in = resp_data & ~xmask, sampled with the same transfer.
  - xmask=0 gives results identical to the undefined build.
- Undefined: no xmask port; data_in = resp_data.

Test Plan:
- Reset with rst pulsed mid-RUN after 3 transfers -> signature=0, pat_count=0, done=0, resp_ready=0 while rst=1 and after release.
- PATTERN_CNT=1, start, one transfer of 0x00000001, golden=0x00000001 -> signature=0x00000001; done=1 two edges after the transfer; pass=1.
- PATTERN_CNT=2, transfers 0x80000000 then 0x00000000, golden=0x04C11DB7 -> signature=0x04C11DB7, pass=1; same run with golden=0 -> pass=0.
- Backpressure and gaps: resp_valid toggled randomly over PATTERN_CNT=256 transfers -> pat_count increments only on transfers; final signature matches the reference model.
  - start pulsed during RUN -> no restart.
  - resp_valid in IDLE -> no change.
- Restart from DONE: start pulse -> done=0 and pass=0 next edge; signature reloaded to seed; second run is bit-identical to the first for the same data.
- RESP_XMASK_EN build: xmask=0xFFFFFFFF with random data over 2 patterns -> signature=0.
  - xmask=0 -> signature equals the undefined-macro build.
